// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage of the 16-bit CPU. Holds the program counter, drives the
// instruction memory read address and captures the combinationally returned
// word into the IF/ID pipeline register. Handles stall, branch/jump redirect
// with flush, HALT detection, and idles while the loader writes memory.
//
// Ports:
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   instruction_write in   loader is writing memory (read data invalid)
//   start             in   single-cycle pulse, begin execution at RESET_PC
//   stall             in   decode cannot accept; hold PC and IF/ID
//   redirect_valid    in   taken branch/jump this cycle
//   redirect_pc [15:0] in  branch/jump target word address
//   address [15:0]    out  instruction memory read address (= pc)
//   instruction_out [15:0] in  memory read data at address
//   if_id_instr [15:0] out registered fetched instruction
//   if_id_pc [15:0]   out  address if_id_instr was read from
//   if_id_valid       out  IF/ID holds a real instruction
//   halted            out  high while in HALT state
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instruction_write,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] address,
    input  logic [15:0] instruction_out,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] pc_r;
    logic [15:0] pc_s;
    logic [15:0] if_id_instr_r;
    logic [15:0] if_id_instr_s;
    logic [15:0] if_id_pc_r;
    logic [15:0] if_id_pc_s;
    logic        if_id_valid_r;
    logic        if_id_valid_s;
    logic        halted_r;

    assign address     = pc_r;
    assign if_id_instr = if_id_instr_r;
    assign if_id_pc    = if_id_pc_r;
    assign if_id_valid = if_id_valid_r;
    assign halted      = halted_r;

    // Next-state logic: state transitions, PC update and IF/ID capture.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        if_id_instr_s = if_id_instr_r;
        if_id_pc_s    = if_id_pc_r;
        if_id_valid_s = if_id_valid_r;
        case (state_r)
            ST_IDLE: begin
                // Stall and redirect are meaningless before execution starts.
                pc_s          = RESET_PC;
                if_id_valid_s = 1'b0;
                if (start && !instruction_write) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (instruction_write) begin
                    state_s       = ST_IDLE;
                    pc_s          = RESET_PC;
                    if_id_valid_s = 1'b0;
                end else if (redirect_valid) begin
                    // Redirect beats stall: the word at the old pc is wrong-path.
                    pc_s          = redirect_pc;
                    if_id_valid_s = 1'b0;
                end else if (stall) begin
                    pc_s          = pc_r;
                end else begin
                    if_id_instr_s = instruction_out;
                    if_id_pc_s    = pc_r;
                    if_id_valid_s = 1'b1;
                    if (instruction_out[15:12] == HALT_OPCODE) begin
                        state_s = ST_HALT;
                    end else begin
                        pc_s = pc_r + 16'd1;
                    end
                end
            end
            ST_HALT: begin
                if (instruction_write) begin
                    state_s       = ST_IDLE;
                    pc_s          = RESET_PC;
                    if_id_valid_s = 1'b0;
                end else if (redirect_valid) begin
                    state_s       = ST_RUN;
                    pc_s          = redirect_pc;
                    if_id_valid_s = 1'b0;
                end else if (start) begin
                    state_s       = ST_RUN;
                    pc_s          = RESET_PC;
                    if_id_valid_s = 1'b0;
                end else if (!stall) begin
                    // Decode has taken the HALT word; nothing new follows it.
                    if_id_valid_s = 1'b0;
                end else begin
                    if_id_valid_s = if_id_valid_r;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                pc_s          = RESET_PC;
                if_id_valid_s = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            if_id_instr_r <= 16'h0000;
            if_id_pc_r    <= 16'h0000;
            if_id_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            if_id_instr_r <= if_id_instr_s;
            if_id_pc_r    <= if_id_pc_s;
            if_id_valid_r <= if_id_valid_s;
            halted_r      <= (state_s == ST_HALT);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for the fetch stage. A bench-side instruction memory answers
// the read address combinationally; an abstract reference of the fetch rules
// is stepped every clock and compared against the DUT on every falling edge,
// with literal expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instruction_write = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] address;
    logic [15:0] instruction_out;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    logic [15:0] ld_addr = 16'h0000;
    logic [15:0] ld_data = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instruction_write (instruction_write),
        .start             (start),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .address           (address),
        .instruction_out   (instruction_out),
        .if_id_instr       (if_id_instr),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: unloaded words read as {0, addr[11:0]} (never HALT).
    logic [15:0] mem [0:65535];
    bit          loaded [0:65535];

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (loaded[a]) return mem[a];
        return {4'h0, a[11:0]};
    endfunction

    assign instruction_out = rd(address);

    // Reference model: mode 0=idle, 1=run, 2=halt.
    int          m_mode  = 0;
    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_ifpc  = 16'h0000;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_pc <= 16'h0000; m_instr <= 16'h0000;
            m_ifpc <= 16'h0000; m_valid <= 1'b0;
        end else begin
            if (instruction_write) begin
                mem[ld_addr]    <= ld_data;
                loaded[ld_addr] <= 1'b1;
                m_mode <= 0; m_pc <= 16'h0000; m_valid <= 1'b0;
            end else if (m_mode == 0) begin
                if (start) m_mode <= 1;
            end else if (redirect_valid) begin
                m_mode <= 1; m_pc <= redirect_pc; m_valid <= 1'b0;
            end else if (m_mode == 2) begin
                if (start) begin
                    m_mode <= 1; m_pc <= 16'h0000; m_valid <= 1'b0;
                end else if (!stall) begin
                    m_valid <= 1'b0;
                end
            end else if (!stall) begin
                m_instr <= rd(m_pc);
                m_ifpc  <= m_pc;
                m_valid <= 1'b1;
                if (rd(m_pc) >= 16'hF000) m_mode <= 2;
                else m_pc <= m_pc + 16'd1;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference model.
    always @(negedge clk) begin
        check("address", address, m_pc);
        check("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        check("halted", {15'd0, halted}, {15'd0, (m_mode == 2)});
        if (m_valid) begin
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_pc", if_id_pc, m_ifpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic pin(input string name, input logic [15:0] d, input logic [15:0] m,
                       input logic [15:0] exp);
        check({name, "_dut"}, d, exp);
        check({name, "_model"}, m, exp);
    endtask

    logic [15:0] prog [0:3];

    initial begin
        prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'h3003; prog[3] = 16'hF000;

        // Reset
        tick(); tick();
        pin("rst_addr", address, m_pc, 16'h0000);
        check("rst_valid", {15'd0, if_id_valid}, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Load program; a start during loading is ignored
        instruction_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_addr = 16'(i); ld_data = prog[i];
            start = (i == 1);
            tick();
        end
        instruction_write = 1'b0; start = 1'b0;
        tick(); tick();
        check("start_in_load_ignored", {15'd0, if_id_valid}, 16'h0000);
        pin("idle_addr", address, m_pc, 16'h0000);

        // Run to HALT
        start = 1'b1; tick(); start = 1'b0;
        pin("run_addr0", address, m_pc, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            pin("run_ifpc", if_id_pc, m_ifpc, 16'(i));
            pin("run_instr", if_id_instr, m_instr, prog[i]);
            check("run_valid", {15'd0, if_id_valid}, 16'h0001);
        end
        pin("halt_addr", address, m_pc, 16'h0003);
        check("halt_flag", {15'd0, halted}, 16'h0001);
        tick();
        check("halt_consumed", {15'd0, if_id_valid}, 16'h0000);
        pin("halt_addr_hold", address, m_pc, 16'h0003);

        // Stall at pc=5
        redirect_valid = 1'b1; redirect_pc = 16'h0004; tick(); redirect_valid = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            pin("stall_addr", address, m_pc, 16'h0005);
            pin("stall_ifpc", if_id_pc, m_ifpc, 16'h0004);
            check("stall_valid", {15'd0, if_id_valid}, 16'h0001);
        end
        stall = 1'b0;
        tick(); pin("resume5", if_id_pc, m_ifpc, 16'h0005);
        tick(); pin("resume6", if_id_pc, m_ifpc, 16'h0006);
        tick(); pin("at8", address, m_pc, 16'h0008);

        // Redirect overrides stall
        redirect_valid = 1'b1; redirect_pc = 16'h0040; stall = 1'b1; tick();
        redirect_valid = 1'b0; stall = 1'b0;
        pin("redir_addr", address, m_pc, 16'h0040);
        check("redir_flush", {15'd0, if_id_valid}, 16'h0000);
        tick();
        pin("redir_ifpc", if_id_pc, m_ifpc, 16'h0040);
        check("redir_valid", {15'd0, if_id_valid}, 16'h0001);

        // Wrap
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF; tick(); redirect_valid = 1'b0;
        tick();
        pin("wrap_ifpc", if_id_pc, m_ifpc, 16'hFFFF);
        pin("wrap_instr", if_id_instr, m_instr, 16'h0FFF);
        pin("wrap_addr", address, m_pc, 16'h0000);
        tick(); tick(); tick(); tick();
        check("rehalt", {15'd0, halted}, 16'h0001);

        // Stall in HALT holds; redirect+start exits via redirect
        stall = 1'b1; tick(); stall = 1'b0;
        check("halt_stall_valid", {15'd0, if_id_valid}, 16'h0001);
        redirect_valid = 1'b1; redirect_pc = 16'h0010; start = 1'b1; tick();
        redirect_valid = 1'b0; start = 1'b0;
        pin("exit_redir_addr", address, m_pc, 16'h0010);
        check("exit_redir_halted", {15'd0, halted}, 16'h0000);
        redirect_valid = 1'b1; redirect_pc = 16'h0003; tick(); redirect_valid = 1'b0;
        tick();
        check("halt_again", {15'd0, halted}, 16'h0001);
        start = 1'b1; tick(); start = 1'b0;
        pin("exit_start_addr", address, m_pc, 16'h0000);
        check("exit_start_halted", {15'd0, halted}, 16'h0000);

        // Load abort at pc=0x22 with a simultaneous start
        redirect_valid = 1'b1; redirect_pc = 16'h0022; tick(); redirect_valid = 1'b0;
        pin("at22", address, m_pc, 16'h0022);
        instruction_write = 1'b1; start = 1'b1; ld_addr = 16'h0030; ld_data = 16'h0030;
        tick();
        instruction_write = 1'b0; start = 1'b0;
        pin("abort_addr", address, m_pc, 16'h0000);
        check("abort_valid", {15'd0, if_id_valid}, 16'h0000);
        tick(); tick();
        check("abort_idle_valid", {15'd0, if_id_valid}, 16'h0000);

        // HALT opcode ignored under stall and under redirect
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        pin("pre_halt_addr", address, m_pc, 16'h0003);
        stall = 1'b1; tick();
        check("halt_op_stall", {15'd0, halted}, 16'h0000);
        stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0050; tick();
        redirect_valid = 1'b0;
        check("halt_op_redir", {15'd0, halted}, 16'h0000);
        pin("halt_op_redir_addr", address, m_pc, 16'h0050);
        tick(); tick();

        // Asynchronous reset mid-run
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("arst_addr", address, 16'h0000);
        check("arst_instr", if_id_instr, 16'h0000);
        check("arst_ifpc", if_id_pc, 16'h0000);
        check("arst_valid", {15'd0, if_id_valid}, 16'h0000);
        check("arst_halted", {15'd0, halted}, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_idle", {15'd0, if_id_valid}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
